xy_shared_reg_arbiter: RTL and testbench

XY_SHARED_REG_ARBITER -- requirements
Module: xy_shared_reg_arbiter

---
 rtl/xy_shared_reg_arbiter.sv | 56 +++++
 tb/tb_xy_shared_reg_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/xy_shared_reg_arbiter.sv
// xy_shared_reg_arbiter: round-robin arbiter granting X increments / Y decrements of a shared register
module xy_shared_reg_arbiter #(
    parameter int WIDTH       = 4,
    parameter int COOL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             X,
    input  logic             Y,
    output logic             gnt_x,
    output logic             gnt_y,
    output logic [WIDTH-1:0] Z,
    output logic             busy,
    output logic             ovf
);
    typedef enum logic [1:0] {IDLE, SERVE_X, SERVE_Y, COOL} state_t;
    state_t     state;
    logic       last_x;
    logic [2:0] cnt;
    assign gnt_x = state == SERVE_X;
    assign gnt_y = state == SERVE_Y;
    assign busy  = state != IDLE;
    // last_x clear after reset makes X the winner of the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            last_x <= 1'b0;
            cnt    <= '0;
            Z      <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= 1'b0;
            case (state)
                IDLE:    state <= (X && (!Y || !last_x)) ? SERVE_X : Y ? SERVE_Y : IDLE;
                SERVE_X: begin
                    Z      <= Z + 1'b1;
                    ovf    <= &Z;
                    last_x <= 1'b1;
                    cnt    <= 3'(COOL_CYCLES - 1);
                    state  <= COOL;
                end
                SERVE_Y: begin
                    Z      <= Z - 1'b1;
                    ovf    <= ~|Z;
                    last_x <= 1'b0;
                    cnt    <= 3'(COOL_CYCLES - 1);
                    state  <= COOL;
                end
                default: begin
                    cnt   <= cnt - 3'd1;
                    state <= (cnt == 3'd0) ? IDLE : COOL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xy_shared_reg_arbiter.sv
// tb_xy_shared_reg_arbiter: directed-vector bench for xy_shared_reg_arbiter
module tb_xy_shared_reg_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0, X = 1'b0, Y = 1'b0;
    logic       gnt_x, gnt_y, busy, ovf;
    logic [3:0] Z;
    logic       reset3 = 1'b0, X3 = 1'b0;
    logic       gnt_x3, gnt_y3, busy3, ovf3;
    logic [3:0] Z3;
    int         n_tests = 0, n_fail = 0;
    int         zm;

    always #5 clk = ~clk;

    xy_shared_reg_arbiter #(.WIDTH(4), .COOL_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .X(X), .Y(Y),
        .gnt_x(gnt_x), .gnt_y(gnt_y), .Z(Z), .busy(busy), .ovf(ovf)
    );

    xy_shared_reg_arbiter #(.WIDTH(4), .COOL_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset3), .X(X3), .Y(1'b0),
        .gnt_x(gnt_x3), .gnt_y(gnt_y3), .Z(Z3), .busy(busy3), .ovf(ovf3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // held in reset with both requests high
        X = 1'b1; Y = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", {Z, gnt_x, gnt_y, busy, ovf}, 0);
        end
        // single held X request
        reset = 1'b1; Y = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            check("x_gnt",  gnt_x, (i % 3) == 0);
            check("x_busy", busy,  (i % 3) != 2);
            check("x_z",    Z,     i / 3 + ((i % 3) != 0));
            check("x_ovf",  ovf,   0);
        end
        X = 1'b0;
        // ties alternate starting with X after reset
        reset = 1'b0; #1; reset = 1'b1;
        X = 1'b1; Y = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_gnt", {gnt_x, gnt_y}, (k % 2 == 0) ? 2'b10 : 2'b01);
            step();
            check("rr_z", Z, (k % 2 == 0) ? 1 : 0);
            check("rr_gnt_off", {gnt_x, gnt_y}, 2'b00);
            step();
            check("rr_idle", busy, 0);
        end
        X = 1'b0; Y = 1'b0;
        // Y pulse from 0 wraps to 15, then 15 -> 14 without wrap
        Y = 1'b1; step(); Y = 1'b0;
        check("dec_gnt", gnt_y, 1);
        step();
        check("dec_wrap_z", Z, 15);
        check("dec_wrap_ovf", ovf, 1);
        step();
        check("dec_ovf_clr", ovf, 0);
        check("dec_z_hold", Z, 15);
        Y = 1'b1; step(); Y = 1'b0;
        step();
        check("dec_z14", Z, 14);
        check("dec_ovf0", ovf, 0);
        step();
        // X serves from 14 through two 15->0 wraps, ending at 5
        zm = 14;
        X = 1'b1;
        for (int k = 0; k < 23; k++) begin
            step(2);
            check("inc_z", Z, (zm + 1) % 16);
            check("inc_ovf", ovf, zm == 15);
            zm = (zm + 1) % 16;
            step();
            check("inc_ovf_clr", ovf, 0);
        end
        // async reset in the middle of SERVE_X
        step();
        check("abort_gnt_pre", gnt_x, 1);
        check("abort_z_pre", Z, 5);
        #3 reset = 1'b0;
        #1;
        check("abort_z", Z, 0);
        check("abort_gnt", {gnt_x, gnt_y, busy, ovf}, 0);
        Y = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        step();
        check("post_rst_gnt", {gnt_x, gnt_y}, 2'b10);
        step();
        check("post_rst_z", Z, 1);
        X = 1'b0; Y = 1'b0;
        // long turnaround instance
        reset3 = 1'b1; X3 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            check("c3_gnt",  gnt_x3, (i % 5) == 0);
            check("c3_busy", busy3,  (i % 5) != 4);
            check("c3_z",    Z3,     i / 5 + ((i % 5) != 0));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
